// File: rtl/output_collector_if.sv
// Parallel handshake bundle between the output-layer MAC, the collector and the max selector.
// The master side drives the beats and the acknowledge; the slave side is the collector.
interface output_collector_if #(
    parameter int DATA_W = 26
);
    logic [DATA_W-1:0] In_Data;
    logic              In_Valid;
    logic              In_First;
    logic              In_Ready;
    logic [DATA_W-1:0] Out_0;
    logic [DATA_W-1:0] Out_1;
    logic [DATA_W-1:0] Out_2;
    logic [DATA_W-1:0] Out_3;
    logic [DATA_W-1:0] Out_4;
    logic [DATA_W-1:0] Out_5;
    logic [DATA_W-1:0] Out_6;
    logic [DATA_W-1:0] Out_7;
    logic [DATA_W-1:0] Out_8;
    logic [DATA_W-1:0] Out_9;
    logic              Frame_Valid;
    logic              Frame_Ack;
    logic              Sync_Err;
    logic [7:0]        Frame_Cnt;

    modport master (
        output In_Data, In_Valid, In_First, Frame_Ack,
        input  In_Ready, Frame_Valid, Sync_Err, Frame_Cnt,
        input  Out_0, Out_1, Out_2, Out_3, Out_4, Out_5, Out_6, Out_7, Out_8, Out_9
    );

    modport slave (
        input  In_Data, In_Valid, In_First, Frame_Ack,
        output In_Ready, Frame_Valid, Sync_Err, Frame_Cnt,
        output Out_0, Out_1, Out_2, Out_3, Out_4, Out_5, Out_6, Out_7, Out_8, Out_9
    );
endinterface

// File: rtl/output_collector.sv
// Gathers ten neuron results into a frozen parallel bank, holds it until acknowledged,
// and flags framing errors (missing or early In_First) stickily.
module output_collector #(
    parameter int DATA_W = 26,
    parameter int N_OUT  = 10
) (
    input  logic                clk,
    input  logic                GlobalReset,
    output_collector_if.slave   bus
);
    localparam logic [3:0] LAST_IDX = 4'(N_OUT - 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t            state_reg;
    logic [3:0]        idx_reg;
    logic [DATA_W-1:0] bank_reg [N_OUT];
    logic              ready_reg;
    logic              frame_valid_reg;
    logic              sync_err_reg;
    logic [7:0]        frame_cnt_reg;

    // ready_reg is held low through reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_reg       <= COLLECT;
            idx_reg         <= 4'd0;
            ready_reg       <= 1'b0;
            frame_valid_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
            frame_cnt_reg   <= 8'd0;
            for (int i = 0; i < N_OUT; i++) begin
                bank_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                COLLECT: begin
                    ready_reg <= 1'b1;
                    if (bus.In_Valid && ready_reg) begin
                        if (bus.In_First) begin
                            bank_reg[0] <= bus.In_Data;
                            idx_reg     <= 4'd1;
                            if (idx_reg != 4'd0) begin
                                sync_err_reg <= 1'b1;
                            end
                        end else if (idx_reg == 4'd0) begin
                            sync_err_reg <= 1'b1;
                        end else begin
                            bank_reg[idx_reg] <= bus.In_Data;
                            if (idx_reg == LAST_IDX) begin
                                idx_reg         <= 4'd0;
                                state_reg       <= HOLD;
                                ready_reg       <= 1'b0;
                                frame_valid_reg <= 1'b1;
                                frame_cnt_reg   <= frame_cnt_reg + 8'd1;
                            end else begin
                                idx_reg <= idx_reg + 4'd1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (bus.Frame_Ack) begin
                        state_reg       <= COLLECT;
                        ready_reg       <= 1'b1;
                        frame_valid_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.In_Ready    = ready_reg;
    assign bus.Frame_Valid = frame_valid_reg;
    assign bus.Sync_Err    = sync_err_reg;
    assign bus.Frame_Cnt   = frame_cnt_reg;
    assign bus.Out_0       = bank_reg[0];
    assign bus.Out_1       = bank_reg[1];
    assign bus.Out_2       = bank_reg[2];
    assign bus.Out_3       = bank_reg[3];
    assign bus.Out_4       = bank_reg[4];
    assign bus.Out_5       = bank_reg[5];
    assign bus.Out_6       = bank_reg[6];
    assign bus.Out_7       = bank_reg[7];
    assign bus.Out_8       = bank_reg[8];
    assign bus.Out_9       = bank_reg[9];
endmodule
